// File: rtl/seq_pkg.sv
// seq_pkg: definitions shared by the serial pattern transmitter and the
// matching sequence detector.
//   SEQ_MAX_LEN  default maximum pattern length in bits
//   SEQ_CNT_W    default width of the repeat and gap fields
//   seq_state_e  FSM state encoding
//   idx_w()      width of a bit index into an n-bit vector (at least 1)
package seq_pkg;

    localparam int SEQ_MAX_LEN = 8;
    localparam int SEQ_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down counter with a zero flag.
//   Clock     rising-edge clock
//   Reset     asynchronous active-high clear
//   load      load load_val (takes priority over dec)
//   load_val  value to load
//   dec       decrement by one
//   count     current value
//   zero      count == 0
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter. On start (in IDLE) it latches a
// pattern and sends bits pat_len..0 MSB-first on w, repeating repeat_cnt+1
// times with gap idle cycles between repetitions, then pulses done.
//   Clock       rising-edge clock
//   Reset       asynchronous active-high reset
//   start       transmit request, sampled only in IDLE
//   pattern     bits to send
//   pat_len     pattern length minus 1
//   repeat_cnt  repetition count minus 1
//   gap         idle cycles between repetitions
//   w           serial output
//   busy        high from acceptance through the DONE cycle
//   done        one-cycle pulse after the final bit
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int MAX_LEN = SEQ_MAX_LEN,
    parameter int CNT_W   = SEQ_CNT_W,
    localparam int LEN_W  = idx_w(MAX_LEN)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic [CNT_W-1:0]   repeat_cnt,
    input  logic [CNT_W-1:0]   gap,
    output logic               w,
    output logic               busy,
    output logic               done
);

    seq_state_e state, nxt;

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   pat_len_q;
    logic [CNT_W-1:0]   gap_q;
    logic               cap;

    logic               bit_ld, bit_dec, bit_zero;
    logic [LEN_W-1:0]   bit_val, bit_idx;
    logic               rep_ld, rep_dec, rep_zero;
    logic [CNT_W-1:0]   rep_cnt;
    logic               gap_ld, gap_dec, gap_zero;
    logic [CNT_W-1:0]   gap_cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    // Transmission parameters are captured once so inputs may change freely
    // while busy.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pattern_q <= '0;
            pat_len_q <= '0;
            gap_q     <= '0;
        end else if (cap) begin
            pattern_q <= pattern;
            pat_len_q <= pat_len;
            gap_q     <= gap;
        end
    end

    always_comb begin
        nxt     = state;
        cap     = 1'b0;
        bit_ld  = 1'b0;
        bit_dec = 1'b0;
        bit_val = pat_len_q;
        rep_ld  = 1'b0;
        rep_dec = 1'b0;
        gap_ld  = 1'b0;
        gap_dec = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    nxt     = ST_SEND;
                    cap     = 1'b1;
                    bit_ld  = 1'b1;
                    bit_val = pat_len;
                    rep_ld  = 1'b1;
                end
            end
            ST_SEND: begin
                if (!bit_zero) begin
                    bit_dec = 1'b1;
                end else if (rep_zero) begin
                    nxt = ST_DONE;
                end else begin
                    rep_dec = 1'b1;
                    if (gap_q != '0) begin
                        nxt    = ST_GAP;
                        gap_ld = 1'b1;
                    end else begin
                        bit_ld = 1'b1;   // back-to-back repetition
                    end
                end
            end
            ST_GAP: begin
                // Counter holds gap-1 on entry, so GAP lasts exactly gap cycles.
                if (gap_zero) begin
                    nxt    = ST_SEND;
                    bit_ld = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    seq_down_counter #(.W(LEN_W)) u_bit_cnt (
        .Clock(Clock), .Reset(Reset), .load(bit_ld), .load_val(bit_val),
        .dec(bit_dec), .count(bit_idx), .zero(bit_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_rep_cnt (
        .Clock(Clock), .Reset(Reset), .load(rep_ld), .load_val(repeat_cnt),
        .dec(rep_dec), .count(rep_cnt), .zero(rep_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_gap_cnt (
        .Clock(Clock), .Reset(Reset), .load(gap_ld), .load_val(gap_q - 1'b1),
        .dec(gap_dec), .count(gap_cnt), .zero(gap_zero)
    );

    assign w    = (state == ST_SEND) && pattern_q[bit_idx];
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [2:0] pat_len = 3'd0;
    logic [3:0] repeat_cnt = 4'd0;
    logic [3:0] gap = 4'd0;
    logic       w, busy, done;

    int total = 0;
    int bad   = 0;

    // 1101 detector fed by w (overlapping), counts hits
    logic [2:0] det_sh;
    int         zcnt;
    logic       det_clr = 1'b1;

    seq_pattern_tx dut (
        .Clock(Clock), .Reset(Reset), .start(start), .pattern(pattern),
        .pat_len(pat_len), .repeat_cnt(repeat_cnt), .gap(gap),
        .w(w), .busy(busy), .done(done)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (det_clr) begin
            det_sh <= 3'b000;
            zcnt   <= 0;
        end else begin
            det_sh <= {det_sh[1:0], w};
            if ({det_sh, w} == 4'b1101) zcnt <= zcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [7:0] p, input logic [2:0] l,
                         input logic [3:0] r, input logic [3:0] g);
        pattern = p; pat_len = l; repeat_cnt = r; gap = g;
    endtask

    task automatic scramble();
        start      = 1'($urandom);
        pattern    = 8'($urandom);
        pat_len    = 3'($urandom);
        repeat_cnt = 4'($urandom);
        gap        = 4'($urandom);
    endtask

    // Pulse start, then check n bit cycles (ew[n-1] first), the DONE cycle
    // and the following idle cycle.
    task automatic run(input string tag, input logic [31:0] ew, input int n, input bit scr);
        @(negedge Clock) start = 1'b1;
        @(posedge Clock);
        #1 start = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge Clock);
            chk({tag, "_w"}, {31'd0, w}, {31'd0, ew[n-i]});
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
            if (scr) scramble();
        end
        @(negedge Clock);
        chk({tag, "_done"}, {29'd0, w, busy, done}, 32'b011);
        if (scr) scramble();
        @(negedge Clock);
        start = 1'b0;
        chk({tag, "_idle"}, {29'd0, w, busy, done}, 32'b000);
    endtask

    initial begin
        // reset state
        #1;
        chk("reset_outs", {29'd0, w, busy, done}, 32'b000);
        @(negedge Clock) Reset = 1'b0;
        @(negedge Clock) det_clr = 1'b0;
        chk("idle_outs", {29'd0, w, busy, done}, 32'b000);

        // single repetition: 1,1,0,1 then done in cycle 5
        setup(8'b0000_1101, 3'd3, 4'd0, 4'd0);
        run("once", 32'b1101, 4, 1'b0);

        // repeat with gap: 1101 00 1101, done in cycle 11
        setup(8'b0000_1101, 3'd3, 4'd1, 4'd2);
        run("gap", 32'b1101001101, 10, 1'b0);

        // loopback into detector, back-to-back repetitions
        @(negedge Clock) det_clr = 1'b1;
        @(negedge Clock) det_clr = 1'b0;
        setup(8'b0000_1101, 3'd3, 4'd2, 4'd0);
        run("b2b", 32'b1101_1101_1101, 12, 1'b0);
        chk("loop_z", 32'(zcnt), 32'd3);

        // one-bit pattern; start during busy is ignored
        setup(8'b0000_0001, 3'd0, 4'd0, 4'd0);
        @(negedge Clock) start = 1'b1;
        @(posedge Clock);
        #1 start = 1'b0;
        @(negedge Clock);
        chk("one_w", {29'd0, w, busy, done}, 32'b110);
        start = 1'b1;
        @(posedge Clock);
        #1 start = 1'b0;
        @(negedge Clock);
        chk("one_done", {29'd0, w, busy, done}, 32'b011);
        @(negedge Clock);
        chk("one_idle", {29'd0, w, busy, done}, 32'b000);
        @(negedge Clock);
        chk("one_ignored", {29'd0, w, busy, done}, 32'b000);

        // async reset during cycle 2
        setup(8'b0000_1101, 3'd3, 4'd0, 4'd0);
        @(negedge Clock) start = 1'b1;
        @(posedge Clock);
        #1 start = 1'b0;
        @(negedge Clock);
        chk("rst_c1", {29'd0, w, busy, done}, 32'b110);
        @(posedge Clock);
        #2 Reset = 1'b1;
        #1;
        chk("rst_async", {29'd0, w, busy, done}, 32'b000);
        @(negedge Clock) Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            chk("rst_quiet", {29'd0, w, busy, done}, 32'b000);
        end
        run("after_rst", 32'b1101, 4, 1'b0);

        // inputs scrambled every cycle while busy
        setup(8'b0000_1101, 3'd3, 4'd0, 4'd0);
        run("scramble", 32'b1101, 4, 1'b1);

        // start held high: one idle cycle between transmissions
        setup(8'b0000_0001, 3'd0, 4'd0, 4'd0);
        @(negedge Clock) start = 1'b1;
        @(negedge Clock);
        chk("hold_c1", {29'd0, w, busy, done}, 32'b110);
        @(negedge Clock);
        chk("hold_c2", {29'd0, w, busy, done}, 32'b011);
        @(negedge Clock);
        chk("hold_c3", {29'd0, w, busy, done}, 32'b000);
        @(negedge Clock);
        chk("hold_c4", {29'd0, w, busy, done}, 32'b110);
        start = 1'b0;
        @(negedge Clock);
        chk("hold_c5", {29'd0, w, busy, done}, 32'b011);
        @(negedge Clock);
        chk("hold_c6", {29'd0, w, busy, done}, 32'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
